// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The master drives operands and carry-in; the slave returns the registered sum and carry-out.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output a, output b, output c, input s, input cout);
  modport slave  (input a, input b, input c, output s, output cout);
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + c, one cycle after capture.
// WIDTH full-adder cells are chained from bit 0 upward, and the result lands in output flops.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  // Majority function of the three cell inputs gives the cell's carry-out.
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    fa_carry = (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    fa_sum = x ^ y ^ z;
  endfunction

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  // Ripple chain: carry enters at bit 0 and leaves from the MSB cell.
  always_comb begin
    w_carry    = {(WIDTH + 1){1'b0}};
    w_sum      = {WIDTH{1'b0}};
    w_carry[0] = bus.c;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]     = fa_sum(bus.a[i], bus.b[i], w_carry[i]);
      w_carry[i+1] = fa_carry(bus.a[i], bus.b[i], w_carry[i]);
    end
  end

  // Output register; an operand set sampled on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=8 sharing one clock and reset.
module tb_full_adder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         s_exp  [8];
    int         co_exp [8];
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       qa;
    logic       qb;
    logic       qc;
    logic [8:0] exp9;
    logic [1:0] exp2;

    s_exp  = '{0, 1, 1, 0, 1, 0, 0, 1};
    co_exp = '{0, 0, 0, 1, 0, 1, 1, 1};
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;

    // Reset held two edges with all-ones operands.
    rst    = 1'b1;
    bus1.a = 1'b1;
    bus1.b = 1'b1;
    bus1.c = 1'b1;
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    bus8.c = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_w1", {bus1.cout, bus1.s}, 64'h0);
      chk("rst_w8", {bus8.cout, bus8.s}, 64'h0);
    end

    // Exhaustive single-bit truth table, one vector per cycle.
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      bus1.a = v[2];
      bus1.b = v[1];
      bus1.c = v[0];
      tick();
      chk($sformatf("tt_s_%0d", v),    {63'h0, bus1.s},    64'(s_exp[v]));
      chk($sformatf("tt_cout_%0d", v), {63'h0, bus1.cout}, 64'(co_exp[v]));
    end

    // Mid-stream reset with a=1,b=0,c=0.
    bus1.a = 1'b1;
    bus1.b = 1'b0;
    bus1.c = 1'b0;
    tick();
    chk("pre_rst", {bus1.cout, bus1.s}, 64'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst", {bus1.cout, bus1.s}, 64'h0);
    rst = 1'b0;
    tick();
    chk("post_rst", {bus1.cout, bus1.s}, 64'h1);

    // Wide-configuration boundary vectors.
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c = 1'b0;
    tick();
    chk("w8_ff_01", {bus8.cout, bus8.s}, 64'h100);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1;
    tick();
    chk("w8_max", {bus8.cout, bus8.s}, 64'h1FF);
    bus8.a = 8'h00; bus8.b = 8'h00; bus8.c = 1'b1;
    tick();
    chk("w8_cin", {bus8.cout, bus8.s}, 64'h001);
    bus8.a = 8'h55; bus8.b = 8'hAA; bus8.c = 1'b0;
    tick();
    chk("w8_alt", {bus8.cout, bus8.s}, 64'h0FF);
    bus8.a = 8'h55; bus8.b = 8'hAA; bus8.c = 1'b1;
    tick();
    chk("w8_ripple", {bus8.cout, bus8.s}, 64'h100);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.c = 1'b0;
    tick();
    chk("w8_msb", {bus8.cout, bus8.s}, 64'h100);

    // Back-to-back random operands on both widths, every cycle checked.
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      qa = 1'($urandom_range(0, 1));
      qb = 1'($urandom_range(0, 1));
      qc = 1'($urandom_range(0, 1));
      bus8.a = ra; bus8.b = rb; bus8.c = rc;
      bus1.a = qa; bus1.b = qb; bus1.c = qc;
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      exp2 = {1'b0, qa} + {1'b0, qb} + {1'b0, qc};
      tick();
      chk($sformatf("rnd8_%0d", k), {bus8.cout, bus8.s}, {55'h0, exp9});
      chk($sformatf("rnd1_%0d", k), {bus1.cout, bus1.s}, {62'h0, exp2});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Registered full adder: sums operands `a` and `b` with carry-in `c` and presents the sum and carry-out one clock after capture. The default configuration is a single-bit cell. The same block scales, via `WIDTH`, to a ripple-carry adder built from per-bit full-adder cells. It serves as the basic arithmetic leaf in datapaths and as the reference cell for adder verification.

## Interface
- `WIDTH`, default 1: operand and sum width in bits; legal range 1..64.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `a`  input  WIDTH: operand A, unsigned.
- `b`  input  WIDTH: operand B, unsigned.
- `c`  input  1: carry-in.
- `s`  output  WIDTH: registered sum bits.
- `cout`  output  1: registered carry-out of the MSB cell.

## Operation
- Combinational core is a chain of WIDTH full-adder cells.
  - Cell i: `sum_i = a[i] ^ b[i] ^ carry_i`.
  - Cell i: `carry_{i+1} = (a[i] & b[i]) | (a[i] & carry_i) | (b[i] & carry_i)`.
  - `carry_0 = c`.
- Arithmetic identity: `{cout, s} = a + b + c`, computed at WIDTH+1 bits with no truncation.
- Maximum result: a = b = 2^WIDTH−1 with c=1 gives s = 2^WIDTH−1, cout=1.
- Overflow is not flagged separately; `cout` is the unsigned overflow indicator.
- On every rising edge of `clk`:
  - If `rst`=1: `s` ← 0 and `cout` ← 0.
  - Otherwise: `s` ← sum and `cout` ← carry of the current `a`, `b`, `c`.
- No enable, handshake or valid signalling; a new operand set is accepted every cycle.
- Inputs are unsigned/raw bit vectors. No sign extension is performed.
- X or Z on inputs propagates per standard Verilog semantics; no masking.
- No internal state exists other than the output register.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on `s`/`cout` immediately after edge N.
- Throughput: 1 result per cycle.
- Reset:
  - Synchronous; takes effect only at a rising edge where `rst`=1.
  - Outputs read 0/0 after the first such edge.
  - Before the first clock edge, outputs are undefined.
- Reset mid-stream: the operand set sampled on a reset edge is discarded. The first post-reset result comes from inputs sampled at the first edge with `rst`=0.
- Simultaneous input change and clock edge: the inputs must meet setup/hold; the combinational carry path is WIDTH cells deep and must close timing at the target clock.
- Outputs are glitch-free, driven directly from flops.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with a=1, b=1, c=1 -> `s`=0, `cout`=0 after each edge.
- Exhaustive WIDTH=1: drive the 8 combinations (a,b,c) = 000..111 on consecutive cycles.
  - Expected (s,cout), one cycle later: 00, 10, 10, 01, 10, 01, 01, 11.
- Back-to-back throughput: change inputs every cycle. Each output must match the inputs of the immediately preceding edge, with no bubbles.
- Mid-stream reset: with a=1, b=0, c=0, pulse `rst` for one edge.
  - Outputs read 0/0 for that cycle.
  - The next cycle reads s=1, cout=0.
- Wide config WIDTH=8: a=8'hFF, b=8'h01, c=0 -> s=8'h00, cout=1. Then a=8'hFF, b=8'hFF, c=1 -> s=8'hFF, cout=1.
- Random WIDTH=8, 1000 cycles: `{cout, s}` equals a+b+c of the previous cycle for every sample.
